// File: rtl/sim_finish_ctrl_pkg.sv
// Shared types for the simulation end-of-test controller.
// Exit causes, FSM states and the default tohost address.
package riscv_sim_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    TOHOST  = 2'd1,
    LOOP    = 2'd2,
    TIMEOUT = 2'd3
  } exit_cause_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } finish_state_e;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0400;

endpackage

// File: rtl/sim_finish_ctrl_if.sv
// Core-side store/retire bundle watched by the finish controller.
// mmio_hit flows back to gate the data-memory write.
interface sim_finish_ctrl_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        retire;
  logic [31:0] retire_pc;
  logic        mmio_hit;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output retire,
    output retire_pc,
    input  mmio_hit
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  retire,
    input  retire_pc,
    output mmio_hit
  );
endinterface

// File: rtl/sim_finish_ctrl_sat_counter.sv
// Saturating up-counter with enable and freeze.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         freeze,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en && !freeze && q != {W{1'b1}}) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sim_finish_ctrl.sv
// End-of-test controller: detects tohost, self-loop or timeout,
// drains a few cycles, then raises a sticky finish_flag.
module sim_finish_ctrl
  import riscv_sim_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
  parameter int          DRAIN_CYCLES   = 3,
  parameter int          LOOP_LIMIT     = 4,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic             clock,
  input  logic             rst,
  sim_finish_ctrl_if.slave bus,
  output logic             finish_flag,
  output logic [1:0]       exit_cause,
  output logic [30:0]      exit_code,
  output logic             pass,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam int RW = $clog2(LOOP_LIMIT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  finish_state_e state, state_nxt;
  exit_cause_e   cause_q, cause_nxt;
  logic [30:0]   code_q;
  logic [DW-1:0] drain_cnt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic [31:0]   last_pc;
  logic          run;
  logic          ev_tohost, ev_loop;
  logic          ev_timeout, ev_any;

  assign run = (state == RUN);

  assign bus.mmio_hit = bus.mem_we &&
    (bus.mem_addr == TOHOST_ADDR);

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk    (clock),
    .rst    (rst),
    .en     (1'b1),
    .freeze (!run),
    .q      (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk    (clock),
    .rst    (rst),
    .en     (bus.retire),
    .freeze (!run),
    .q      (instret_count)
  );

  // rep_cnt==0 means no retire seen yet, so the first PC never matches
  always_comb begin
    rep_nxt = rep_cnt;
    if (bus.retire) begin
      if (rep_cnt != '0 && bus.retire_pc == last_pc)
        rep_nxt = rep_cnt + RW'(1);
      else
        rep_nxt = RW'(1);
    end
  end

  assign ev_tohost  = run && bus.mmio_hit &&
    bus.mem_wdata[0];
  assign ev_loop    = run && bus.retire &&
    (rep_nxt == RW'(LOOP_LIMIT));
  assign ev_timeout = run && (cycle_count == TO_LAST);
  assign ev_any     = ev_tohost | ev_loop | ev_timeout;

  always_comb begin
    cause_nxt = NONE;
    priority case (1'b1)
      ev_tohost:  cause_nxt = TOHOST;
      ev_loop:    cause_nxt = LOOP;
      ev_timeout: cause_nxt = TIMEOUT;
      default:    cause_nxt = NONE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
      last_pc <= '0;
    end else if (run && bus.retire) begin
      rep_cnt <= rep_nxt;
      last_pc <= bus.retire_pc;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cause_q   <= NONE;
      code_q    <= '0;
      drain_cnt <= '0;
    end else if (ev_any) begin
      cause_q   <= cause_nxt;
      code_q    <= (cause_nxt == TOHOST) ?
        bus.mem_wdata[31:1] : '0;
      drain_cnt <= DW'(DRAIN_CYCLES - 1);
    end else if (state == DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - DW'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (ev_any) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    finish_flag = (state == DONE);
    exit_cause  = cause_q;
    exit_code   = code_q;
    pass        = (cause_q == TOHOST) && (code_q == '0);
  end

endmodule
